// File: rtl/ula_pkg.sv
// Shared definitions for the multicycle ALU: opcodes, FSM states and the
// combinational single-cycle operation evaluated on sign-extended operands.
package ula_pkg;

  localparam int MAX_W = 64;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MULT  = 4'b0011;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_MULTU = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_DIVU  = 4'b1000;
  localparam logic [3:0] OP_PASSA = 4'b1010;
  localparam logic [3:0] OP_XNOR  = 4'b1100;
  localparam logic [3:0] OP_NOTA  = 4'b1110;
  localparam logic [3:0] OP_NOTB  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic logic is_iter_op(input logic [3:0] f);
    return (f == OP_MULT) || (f == OP_MULTU) || (f == OP_DIV) || (f == OP_DIVU);
  endfunction

  // Operands arrive sign-extended to MAX_W, so the low WIDTH bits of every
  // result are correct and SLT is a plain signed compare.
  function automatic wide_t single_op(input logic [3:0] f, input wide_t a, input wide_t b);
    wide_t r;
    r = '0;
    case (f)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XNOR:  r = ~(a ^ b);
      OP_NOTA:  r = ~a;
      OP_NOTB:  r = ~b;
      OP_PASSA: r = a;
      OP_SLT:   r = (a < b) ? wide_t'(1) : '0;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ula_muldiv_iter.sv
// Radix-2 iterative datapath: shift-add multiplier and restoring divider
// sharing one accumulator, one shift register and one iteration counter.
module ula_muldiv_iter
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic             is_mul,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   acc_q, acc_d, quo_q, quo_d, m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mul_q, mul_d, neg_q, neg_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, shifted;
  logic [2*WIDTH-1:0] prod, prod_neg;

  always_comb begin
    acc_d     = acc_q;
    quo_d     = quo_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    mul_d     = mul_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    sum       = '0;
    shifted   = '0;
    a_neg     = is_signed && a[WIDTH-1];
    b_neg     = is_signed && b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;

    if (load) begin
      acc_d     = '0;
      quo_d     = a_mag;
      m_d       = b_mag;
      cnt_d     = CW'(WIDTH);
      mul_d     = is_mul;
      neg_d     = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      div0_d    = !is_mul && (b == '0);
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
      if (mul_q) begin
        sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, m_q} : '0);
        acc_d = sum[WIDTH:1];
        quo_d = {sum[0], quo_q[WIDTH-1:1]};
      end else begin
        // A zero divisor always "fits", which leaves quotient all ones and
        // remainder equal to the dividend magnitude.
        shifted = {acc_q, quo_q[WIDTH-1]};
        if (shifted >= {1'b0, m_q}) begin
          acc_d = shifted[WIDTH-1:0] - m_q;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  // Results are taken from the next-state values so the final iteration and
  // the sign fix-up land together on the edge that enters DONE.
  always_comb begin
    prod     = {acc_d, quo_d};
    prod_neg = -prod;
    if (mul_q) begin
      {res_hi, res_lo} = neg_q ? prod_neg : prod;
    end else begin
      res_lo = div0_q ? '1 : (neg_q ? -quo_d : quo_d);
      res_hi = neg_rem_q ? -acc_d : acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      quo_q     <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      mul_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      mul_q     <= mul_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign last = run && (cnt_q == CW'(1));
  assign div0 = div0_q;

endmodule

// File: rtl/ula_multiciclo.sv
// Multicycle ALU: single-cycle logic/arith ops complete in one cycle, mul/div
// run WIDTH radix-2 iterations. Handshake: start is accepted only while busy=0
// (state IDLE); results are valid in the single cycle where done=1.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       f,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RES,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output state_e           state_dbg
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, lo_q, lo_d, single_res;
  logic             zero_q, zero_d, busy_q, busy_d, done_q, done_d, div0_q, div0_d;
  logic             iter_load, it_last, it_div0;
  logic [WIDTH-1:0] it_hi, it_lo;
  wide_t            a_ext, b_ext;

  assign a_ext      = wide_t'($signed(A));
  assign b_ext      = wide_t'($signed(B));
  assign single_res = WIDTH'(single_op(f, a_ext, b_ext));
  assign iter_load  = (state_q == IDLE) && start && is_iter_op(f);

  ula_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (iter_load),
    .run       (state_q == RUN),
    .is_mul    ((f == OP_MULT) || (f == OP_MULTU)),
    .is_signed ((f == OP_MULT) || (f == OP_DIV)),
    .a         (A),
    .b         (B),
    .last      (it_last),
    .res_hi    (it_hi),
    .res_lo    (it_lo),
    .div0      (it_div0)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_iter_op(f)) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            res_d   = single_res;
            zero_d  = (single_res == '0);
            div0_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (it_last) begin
          state_d = DONE;
          res_d   = it_lo;
          zero_d  = (it_lo == '0);
          hi_d    = it_hi;
          lo_d    = it_lo;
          div0_d  = it_div0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign RES       = res_q;
  assign zero      = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div0      = div0_q;
  assign state_dbg = state_q;

endmodule
